// File: rtl/avr_cpu_pkg.sv
// Purpose: shared constants for the AVR CPU execution stage (op codes, SREG bit indices, FSM states).
// Latency: n/a (package only).
// Backpressure: n/a.
package avr_cpu_pkg;

  // ALU op codes as presented by the decoder
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADC  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_SBC  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_EOR  = 4'h6;
  localparam logic [3:0] OP_MOV  = 4'h7;
  localparam logic [3:0] OP_COM  = 4'h8;
  localparam logic [3:0] OP_NEG  = 4'h9;
  localparam logic [3:0] OP_INC  = 4'hA;
  localparam logic [3:0] OP_DEC  = 4'hB;
  localparam logic [3:0] OP_LSR  = 4'hC;
  localparam logic [3:0] OP_ROR  = 4'hD;
  localparam logic [3:0] OP_ADIW = 4'hE;
  localparam logic [3:0] OP_SBIW = 4'hF;

  // SREG layout {I,T,H,S,V,N,Z,C}
  localparam int SREG_I = 7;
  localparam int SREG_T = 6;
  localparam int SREG_H = 5;
  localparam int SREG_S = 4;
  localparam int SREG_V = 3;
  localparam int SREG_N = 2;
  localparam int SREG_Z = 1;
  localparam int SREG_C = 0;

  // Sets of SREG bits touched by each op class
  localparam logic [7:0] MASK_HSVNZC = 8'h3F;
  localparam logic [7:0] MASK_SVNZC  = 8'h1F;
  localparam logic [7:0] MASK_SVNZ   = 8'h1E;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_WORD_HI = 1'b1
  } alu_state_e;

endpackage

// File: rtl/avr_cpu_alu_flags.sv
// Purpose: combinational SREG flag generation for the 8-bit ALU ops.
// Latency: purely combinational.
// Backpressure: none.
// Ports: op code, operand bits d7/d3/d0 (Rd) and b7/b3 (Rr/imm), 8-bit result,
//        previous Z (for SBC); outputs new flag values plus a mask of bits the op owns.
module avr_cpu_alu_flags
  import avr_cpu_pkg::*;
(
  input  logic [3:0] op,
  input  logic       d7,
  input  logic       d3,
  input  logic       d0,
  input  logic       b7,
  input  logic       b3,
  input  logic [7:0] res,
  input  logic       z_old,
  output logic [7:0] flag_val,
  output logic [7:0] flag_mask
);

  logic h, v, c, n, z, r7, r3;

  always_comb begin
    r7        = res[7];
    r3        = res[3];
    n         = r7;
    z         = (res == 8'h00);
    h         = 1'b0;
    v         = 1'b0;
    c         = 1'b0;
    flag_mask = 8'h00;
    case (op)
      OP_ADD, OP_ADC: begin
        h         = (d3 & b3) | (b3 & ~r3) | (~r3 & d3);
        v         = (d7 & b7 & ~r7) | (~d7 & ~b7 & r7);
        c         = (d7 & b7) | (b7 & ~r7) | (~r7 & d7);
        flag_mask = MASK_HSVNZC;
      end
      OP_SUB, OP_SBC: begin
        h         = (~d3 & b3) | (b3 & r3) | (r3 & ~d3);
        v         = (d7 & ~b7 & ~r7) | (~d7 & b7 & r7);
        c         = (~d7 & b7) | (b7 & r7) | (r7 & ~d7);
        // SBC chains Z across bytes of a multi-byte compare
        if (op == OP_SBC) z = z_old & z;
        flag_mask = MASK_HSVNZC;
      end
      OP_NEG: begin
        h         = r3 | d3;
        v         = (res == 8'h80);
        c         = (res != 8'h00);
        flag_mask = MASK_HSVNZC;
      end
      OP_AND, OP_OR, OP_EOR: begin
        flag_mask = MASK_SVNZ;
      end
      OP_COM: begin
        c         = 1'b1;
        flag_mask = MASK_SVNZC;
      end
      OP_INC: begin
        v         = (res == 8'h80);
        flag_mask = MASK_SVNZ;
      end
      OP_DEC: begin
        v         = (res == 8'h7F);
        flag_mask = MASK_SVNZ;
      end
      OP_LSR, OP_ROR: begin
        c         = d0;
        v         = n ^ d0;
        flag_mask = MASK_SVNZC;
      end
      default: flag_mask = 8'h00;  // MOV and word ops: no 8-bit flag update
    endcase

    flag_val         = 8'h00;
    flag_val[SREG_H] = h;
    flag_val[SREG_S] = n ^ v;
    flag_val[SREG_V] = v;
    flag_val[SREG_N] = n;
    flag_val[SREG_Z] = z;
    flag_val[SREG_C] = c;
  end

endmodule

// File: rtl/avr_cpu_alu.sv
// Purpose: AVR execution stage - 8-bit ALU, SREG, write-back, ADIW/SBIW two-cycle sequencing.
// Latency: 8-bit ops write back same cycle, SREG next cycle; word ops 2 cycles, SREG in cycle 2.
// Backpressure: busy high during the high-byte cycle; decoder holds its op, op_valid ignored.
// Ports: clk/rst (sync, active-high); op_valid/op/use_imm/imm/dec_d_addr from decoder;
//        d_addr to register file, d_data/r_data from register file, res/res_we write-back;
//        sreg_wdata/sreg_we I/O write into SREG; sreg, busy outputs.
// Build option: define AVR_ALU_WORD_OPS_EN to enable ADIW/SBIW; otherwise op E/F is a NOP.
module avr_cpu_alu
  import avr_cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       op_valid,
  input  logic [3:0] op,
  input  logic       use_imm,
  input  logic [7:0] imm,
  input  logic [4:0] dec_d_addr,
  output logic [4:0] d_addr,
  input  logic [7:0] d_data,
  input  logic [7:0] r_data,
  output logic [7:0] res,
  output logic       res_we,
  output logic       busy,
  input  logic [7:0] sreg_wdata,
  input  logic       sreg_we,
  output logic [7:0] sreg
);

  logic [7:0] opb;
  logic       c_old;
  logic [7:0] alu_res;
  logic       alu_wr;
  logic [7:0] flag_val;
  logic [7:0] flag_mask;
  logic       word_hi;
  logic       fire;
  logic [7:0] upd_val;
  logic [7:0] upd_mask;
  logic [7:0] sreg_base;

  assign opb   = use_imm ? imm : r_data;
  assign c_old = sreg[SREG_C];
  assign fire  = op_valid & ~word_hi;
  assign busy  = word_hi;

  // 8-bit datapath
  always_comb begin
    alu_res = 8'h00;
    alu_wr  = 1'b1;
    case (op)
      OP_ADD:  alu_res = d_data + opb;
      OP_ADC:  alu_res = d_data + opb + {7'b0, c_old};
      OP_SUB:  alu_res = d_data - opb;
      OP_SBC:  alu_res = d_data - opb - {7'b0, c_old};
      OP_AND:  alu_res = d_data & opb;
      OP_OR:   alu_res = d_data | opb;
      OP_EOR:  alu_res = d_data ^ opb;
      OP_MOV:  alu_res = opb;
      OP_COM:  alu_res = ~d_data;
      OP_NEG:  alu_res = 8'h00 - d_data;
      OP_INC:  alu_res = d_data + 8'h01;
      OP_DEC:  alu_res = d_data - 8'h01;
      OP_LSR:  alu_res = {1'b0, d_data[7:1]};
      OP_ROR:  alu_res = {c_old, d_data[7:1]};
      default: alu_wr  = 1'b0;  // word ops take the separate path below
    endcase
  end

  avr_cpu_alu_flags u_flags (
    .op        (op),
    .d7        (d_data[7]),
    .d3        (d_data[3]),
    .d0        (d_data[0]),
    .b7        (opb[7]),
    .b3        (opb[3]),
    .res       (alu_res),
    .z_old     (sreg[SREG_Z]),
    .flag_val  (flag_val),
    .flag_mask (flag_mask)
  );

`ifdef AVR_ALU_WORD_OPS_EN
  alu_state_e state;
  logic [3:0] base_hi;    // register pair index: base[4:1]
  logic       wcarry;     // carry/borrow out of the low byte
  logic       low_zero;
  logic       word_sub;
  logic       is_word;
  logic [8:0] lo9;
  logic [7:0] hi_res;
  logic       r15, rdh7, wv, wc, wz;

  assign word_hi = (state == ST_WORD_HI);
  assign is_word = (op == OP_ADIW) | (op == OP_SBIW);
  assign lo9     = (op == OP_SBIW) ? ({1'b0, d_data} - {3'b000, imm[5:0]})
                                   : ({1'b0, d_data} + {3'b000, imm[5:0]});
  assign hi_res  = word_sub ? (d_data - {7'b0, wcarry}) : (d_data + {7'b0, wcarry});

  // 16-bit flags: d_data is Rdh during the high-byte cycle
  assign r15  = hi_res[7];
  assign rdh7 = d_data[7];
  assign wv   = word_sub ? (rdh7 & ~r15) : (~rdh7 & r15);
  assign wc   = word_sub ? (r15 & ~rdh7) : (~r15 & rdh7);  // carry/borrow out of bit 15
  assign wz   = low_zero & (hi_res == 8'h00);

  // Force the low address while in reset so the register file never sees a stale pair index
  assign d_addr = (word_hi & ~rst) ? {base_hi, 1'b1} : dec_d_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      base_hi  <= 4'h0;
      wcarry   <= 1'b0;
      low_zero <= 1'b0;
      word_sub <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fire && is_word) begin
            state    <= ST_WORD_HI;
            base_hi  <= dec_d_addr[4:1];
            wcarry   <= lo9[8];
            low_zero <= (lo9[7:0] == 8'h00);
            word_sub <= (op == OP_SBIW);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
`else
  assign word_hi = 1'b0;
  assign d_addr  = dec_d_addr;
`endif

  // Write-back and SREG update selection
  always_comb begin
    res      = alu_res;
    res_we   = fire & alu_wr;
    upd_val  = flag_val;
    upd_mask = fire ? flag_mask : 8'h00;
`ifdef AVR_ALU_WORD_OPS_EN
    if (word_hi) begin
      res              = hi_res;
      res_we           = 1'b1;
      upd_mask         = MASK_SVNZC;
      upd_val          = 8'h00;
      upd_val[SREG_S]  = r15 ^ wv;
      upd_val[SREG_V]  = wv;
      upd_val[SREG_N]  = r15;
      upd_val[SREG_Z]  = wz;
      upd_val[SREG_C]  = wc;
    end else if (fire && is_word) begin
      res      = lo9[7:0];
      res_we   = 1'b1;
      upd_mask = 8'h00;  // SREG settles after the high byte
    end
`endif
    if (rst) res_we = 1'b0;
  end

  // An I/O write supplies the bits the ALU is not touching this cycle
  assign sreg_base = sreg_we ? sreg_wdata : sreg;

  always_ff @(posedge clk) begin
    if (rst) sreg <= 8'h00;
    else     sreg <= (sreg_base & ~upd_mask) | (upd_val & upd_mask);
  end

endmodule

// File: tb/tb_avr_cpu_alu.sv
module tb_avr_cpu_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic       op_valid;
  logic [3:0] op;
  logic       use_imm;
  logic [7:0] imm;
  logic [4:0] dec_d_addr;
  logic [4:0] d_addr;
  logic [7:0] d_data;
  logic [7:0] r_data;
  logic [7:0] res;
  logic       res_we;
  logic       busy;
  logic [7:0] sreg_wdata;
  logic       sreg_we;
  logic [7:0] sreg;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0] op;
    logic       ui;
    logic [7:0] d;
    logic [7:0] b;
    logic [7:0] res;
    logic [7:0] sreg;
  } vec_t;

  vec_t tbl [13];

  always #5 clk = ~clk;

  avr_cpu_alu dut (
    .clk        (clk),
    .rst        (rst),
    .op_valid   (op_valid),
    .op         (op),
    .use_imm    (use_imm),
    .imm        (imm),
    .dec_d_addr (dec_d_addr),
    .d_addr     (d_addr),
    .d_data     (d_data),
    .r_data     (r_data),
    .res        (res),
    .res_we     (res_we),
    .busy       (busy),
    .sreg_wdata (sreg_wdata),
    .sreg_we    (sreg_we),
    .sreg       (sreg)
  );

  task automatic test_reset();
    rst = 1'b1; op_valid = 1'b1; op = 4'h0; use_imm = 1'b0; imm = 8'h00;
    dec_d_addr = 5'd7; d_data = 8'h01; r_data = 8'h01; sreg_we = 1'b1; sreg_wdata = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (res_we !== 1'b0) begin failures++; $display("FAIL reset_res_we got=%b exp=0", res_we); end
    checks++; if (sreg !== 8'h00) begin failures++; $display("FAIL reset_sreg got=%h exp=00", sreg); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (d_addr !== 5'd7) begin failures++; $display("FAIL reset_d_addr got=%0d exp=7", d_addr); end
    rst = 1'b0; op_valid = 1'b0; sreg_we = 1'b0; sreg_wdata = 8'h00;
  endtask

  task automatic test_add_sub();
    // ADD 7F+01
    op_valid = 1'b1; op = 4'h0; d_data = 8'h7F; r_data = 8'h01; #1;
    checks++; if (res !== 8'h80) begin failures++; $display("FAIL add_res got=%h exp=80", res); end
    checks++; if (res_we !== 1'b1) begin failures++; $display("FAIL add_we got=%b exp=1", res_we); end
    @(posedge clk); #1;
    checks++; if (sreg !== 8'h2C) begin failures++; $display("FAIL add_sreg got=%h exp=2C", sreg); end
    // SBC with Z previously clear: zero result must not set Z
    op = 4'h3; d_data = 8'h10; r_data = 8'h10; #1;
    checks++; if (res !== 8'h00) begin failures++; $display("FAIL sbc0_res got=%h exp=00", res); end
    @(posedge clk); #1;
    checks++; if (sreg !== 8'h00) begin failures++; $display("FAIL sbc0_sreg got=%h exp=00", sreg); end
    // SUB equal operands
    op = 4'h2; #1;
    checks++; if (res !== 8'h00) begin failures++; $display("FAIL sub_res got=%h exp=00", res); end
    @(posedge clk); #1;
    checks++; if (sreg !== 8'h02) begin failures++; $display("FAIL sub_sreg got=%h exp=02", sreg); end
    // SBC with Z set and C clear keeps Z
    op = 4'h3; #1;
    checks++; if (res !== 8'h00) begin failures++; $display("FAIL sbc1_res got=%h exp=00", res); end
    @(posedge clk); #1;
    checks++; if (sreg !== 8'h02) begin failures++; $display("FAIL sbc1_sreg got=%h exp=02", sreg); end
    op_valid = 1'b0;
  endtask

`ifdef AVR_ALU_WORD_OPS_EN
  task automatic test_adiw();
    op_valid = 1'b1; op = 4'hE; use_imm = 1'b1; imm = 8'h01; dec_d_addr = 5'd24; d_data = 8'hFF; #1;
    checks++; if (res !== 8'h00 || res_we !== 1'b1 || d_addr !== 5'd24 || busy !== 1'b0) begin
      failures++; $display("FAIL adiw_lo got res=%h we=%b addr=%0d busy=%b exp res=00 we=1 addr=24 busy=0", res, res_we, d_addr, busy); end
    @(posedge clk); #1;
    op_valid = 1'b0; d_data = 8'h00; #1;
    checks++; if (res !== 8'h01 || res_we !== 1'b1 || d_addr !== 5'd25 || busy !== 1'b1) begin
      failures++; $display("FAIL adiw_hi got res=%h we=%b addr=%0d busy=%b exp res=01 we=1 addr=25 busy=1", res, res_we, d_addr, busy); end
    @(posedge clk); #1;
    checks++; if (sreg !== 8'h00 || busy !== 1'b0) begin
      failures++; $display("FAIL adiw_sreg got sreg=%h busy=%b exp sreg=00 busy=0", sreg, busy); end
    use_imm = 1'b0;
  endtask

  task automatic test_sbiw();
    op_valid = 1'b1; op = 4'hF; use_imm = 1'b1; imm = 8'h01; dec_d_addr = 5'd26; d_data = 8'h00; #1;
    checks++; if (res !== 8'hFF || res_we !== 1'b1 || d_addr !== 5'd26) begin
      failures++; $display("FAIL sbiw_lo got res=%h we=%b addr=%0d exp res=FF we=1 addr=26", res, res_we, d_addr); end
    @(posedge clk); #1;
    op_valid = 1'b0; d_data = 8'h00; #1;
    checks++; if (res !== 8'hFF || res_we !== 1'b1 || d_addr !== 5'd27 || busy !== 1'b1) begin
      failures++; $display("FAIL sbiw_hi got res=%h we=%b addr=%0d busy=%b exp res=FF we=1 addr=27 busy=1", res, res_we, d_addr, busy); end
    @(posedge clk); #1;
    checks++; if (sreg !== 8'h15) begin failures++; $display("FAIL sbiw_sreg got=%h exp=15", sreg); end
    use_imm = 1'b0;
  endtask

  task automatic test_word_reset();
    op_valid = 1'b1; op = 4'hE; use_imm = 1'b1; imm = 8'h05; dec_d_addr = 5'd28; d_data = 8'h10; #1;
    checks++; if (res !== 8'h15) begin failures++; $display("FAIL wrst_lo got=%h exp=15", res); end
    @(posedge clk); #1;
    op_valid = 1'b0; rst = 1'b1; d_data = 8'h00; #1;
    checks++; if (res_we !== 1'b0) begin failures++; $display("FAIL wrst_we got=%b exp=0", res_we); end
    @(posedge clk); #1;
    checks++; if (sreg !== 8'h00 || busy !== 1'b0 || d_addr !== 5'd28) begin
      failures++; $display("FAIL wrst_state got sreg=%h busy=%b addr=%0d exp sreg=00 busy=0 addr=28", sreg, busy, d_addr); end
    rst = 1'b0; use_imm = 1'b0;
  endtask

  task automatic test_back_to_back();
    // word op with the decoder still presenting an ADD during the high-byte cycle
    op_valid = 1'b1; op = 4'hE; use_imm = 1'b1; imm = 8'h01; dec_d_addr = 5'd30; d_data = 8'hFF; #1;
    @(posedge clk); #1;
    op = 4'h0; use_imm = 1'b0; d_data = 8'h00; r_data = 8'h44; #1;
    checks++; if (res !== 8'h01 || d_addr !== 5'd31) begin
      failures++; $display("FAIL b2b_hold got res=%h addr=%0d exp res=01 addr=31", res, d_addr); end
    @(posedge clk); #1;
    d_data = 8'h7F; r_data = 8'h01; #1;
    checks++; if (res !== 8'h80 || res_we !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL b2b_next got res=%h we=%b busy=%b exp res=80 we=1 busy=0", res, res_we, busy); end
    @(posedge clk); #1;
    checks++; if (sreg !== 8'h2C) begin failures++; $display("FAIL b2b_sreg got=%h exp=2C", sreg); end
    op_valid = 1'b0;
  endtask
`else
  task automatic test_word_nop();
    op_valid = 1'b1; op = 4'hE; use_imm = 1'b1; imm = 8'h01; dec_d_addr = 5'd24; d_data = 8'hFF; #1;
    checks++; if (res_we !== 1'b0 || busy !== 1'b0 || d_addr !== 5'd24) begin
      failures++; $display("FAIL nop_comb got we=%b busy=%b addr=%0d exp we=0 busy=0 addr=24", res_we, busy, d_addr); end
    @(posedge clk); #1;
    op_valid = 1'b0; #1;
    checks++; if (sreg !== 8'h02 || busy !== 1'b0) begin
      failures++; $display("FAIL nop_sreg got sreg=%h busy=%b exp sreg=02 busy=0", sreg, busy); end
    use_imm = 1'b0;
  endtask
`endif

  // Back-to-back stream of 8-bit ops; each row's SREG depends on the previous rows
  task automatic test_alu_ops();
    tbl[0]  = '{4'h8, 1'b0, 8'h00, 8'h00, 8'hFF, 8'h15};  // COM
    tbl[1]  = '{4'h1, 1'b0, 8'h0F, 8'h00, 8'h10, 8'h20};  // ADC, C=1
    tbl[2]  = '{4'h4, 1'b1, 8'hF0, 8'h80, 8'h80, 8'h34};  // AND imm
    tbl[3]  = '{4'h6, 1'b0, 8'h55, 8'h55, 8'h00, 8'h22};  // EOR
    tbl[4]  = '{4'h5, 1'b1, 8'h00, 8'h01, 8'h01, 8'h20};  // OR imm
    tbl[5]  = '{4'h9, 1'b0, 8'h80, 8'h00, 8'h80, 8'h0D};  // NEG 0x80
    tbl[6]  = '{4'hB, 1'b0, 8'h80, 8'h00, 8'h7F, 8'h19};  // DEC
    tbl[7]  = '{4'hA, 1'b0, 8'hFF, 8'h00, 8'h00, 8'h03};  // INC wrap
    tbl[8]  = '{4'hD, 1'b0, 8'h02, 8'h00, 8'h81, 8'h0C};  // ROR, C=1
    tbl[9]  = '{4'h7, 1'b0, 8'h00, 8'hA5, 8'hA5, 8'h0C};  // MOV
    tbl[10] = '{4'h2, 1'b0, 8'h00, 8'h01, 8'hFF, 8'h35};  // SUB borrow
    tbl[11] = '{4'h0, 1'b1, 8'hFF, 8'h01, 8'h00, 8'h23};  // ADD imm carry
    tbl[12] = '{4'hC, 1'b0, 8'h80, 8'h00, 8'h40, 8'h20};  // LSR
    op_valid = 1'b1;
    for (int i = 0; i < 13; i++) begin
      op = tbl[i].op; use_imm = tbl[i].ui; d_data = tbl[i].d;
      r_data = tbl[i].ui ? ~tbl[i].b : tbl[i].b;
      imm    = tbl[i].ui ? tbl[i].b : ~tbl[i].b;
      #1;
      checks++; if (res !== tbl[i].res || res_we !== 1'b1) begin
        failures++; $display("FAIL alu_res[%0d] got res=%h we=%b exp res=%h we=1", i, res, res_we, tbl[i].res); end
      @(posedge clk); #1;
      checks++; if (sreg !== tbl[i].sreg) begin
        failures++; $display("FAIL alu_sreg[%0d] got=%h exp=%h", i, sreg, tbl[i].sreg); end
    end
    op_valid = 1'b0; use_imm = 1'b0;
  endtask

  task automatic test_sreg_write();
    sreg_we = 1'b1; sreg_wdata = 8'h5A; #1;
    @(posedge clk); #1;
    checks++; if (sreg !== 8'h5A) begin failures++; $display("FAIL sreg_io got=%h exp=5A", sreg); end
    // LSR with simultaneous I/O write: S,V,N,Z,C from ALU, I,T,H from the write
    op_valid = 1'b1; op = 4'hC; d_data = 8'h01; sreg_wdata = 8'h80; #1;
    checks++; if (res !== 8'h00) begin failures++; $display("FAIL lsr_io_res got=%h exp=00", res); end
    @(posedge clk); #1;
    checks++; if (sreg !== 8'h9B) begin failures++; $display("FAIL lsr_io_sreg got=%h exp=9B", sreg); end
    op_valid = 1'b0; sreg_we = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_add_sub();
`ifdef AVR_ALU_WORD_OPS_EN
    test_adiw();
    test_sbiw();
`else
    test_word_nop();
`endif
    test_alu_ops();
    test_sreg_write();
`ifdef AVR_ALU_WORD_OPS_EN
    test_word_reset();
    test_back_to_back();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
